fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the synchronous FIFO between NUM_REQ requesters.
- Grants one requester at a time and drives fifo_wr_en/fifo_data_in from registers.
- Checks the FIFO's wr_ack/overflow response for each issued write, and tracks dropped writes.
- Sits between the producer blocks and the FIFO write interface; the FIFO read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 16, width of each request word; matches the FIFO data_in width
- CNT_WIDTH, 8, width of the saturating drop counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester write request, held until granted
- req_data  input  NUM_REQ*DATA_WIDTH  packed request words; requester i in bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_grant  output  NUM_REQ  one-hot, one-cycle pulse; req_data[i] captured on this edge
- grant_id  output  $clog2(NUM_REQ)  index of the requester owning the in-flight write
- fifo_wr_en  output  1  FIFO write enable, registered
- fifo_data_in  output  DATA_WIDTH  FIFO write data, registered
- fifo_full  input  1  FIFO full flag
- fifo_wr_ack  input  1  FIFO write acknowledge, one cycle after wr_en
- fifo_overflow  input  1  FIFO overflow, one cycle after a rejected wr_en
- busy  output  1  high whenever state != IDLE
- drop_count  output  CNT_WIDTH  saturating count of writes not acknowledged

Behaviour:
- Reset (async, rst=1):
  - State = IDLE, rr_ptr = 0.
  - req_grant = 0, grant_id = 0, fifo_wr_en = 0, fifo_data_in = 0, busy = 0, drop_count = 0.
  - Any in-flight write is abandoned and not counted.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid and fifo_full=0, select the first valid requester searching upward from rr_ptr, wrapping at NUM_REQ-1.
  - On that edge: pulse req_grant[sel]=1, latch req_data[sel] into fifo_data_in, set grant_id=sel, set fifo_wr_en=1, go to ISSUE.
  - If fifo_full=1, no grant; stay in IDLE.
- ISSUE:
  - fifo_wr_en is high for exactly this one cycle; the FIFO samples it on the next edge.
  - Go to WAIT; fifo_wr_en returns to 0.
- WAIT: sample the FIFO response.
  - fifo_wr_ack=1: success. rr_ptr = (grant_id+1) mod NUM_REQ; go to IDLE.
  - fifo_overflow=1, or neither flag set: failure. Handling is set by the optional feature.
  - wr_ack and overflow both high is illegal; treat as success and fire an assertion.
- Write timing:
  - One write per 3 cycles maximum. req_grant leads fifo_wr_en by 0 cycles (same edge); the response is read 2 cycles after the grant.
  - fifo_full is always current in IDLE, because no write is in flight.
- Requesters:
  - req_valid may drop without a grant; it is never granted in that cycle.
  - req_data only needs to be stable in the grant cycle.
- Fairness: a requester with continuous req_valid waits at most NUM_REQ-1 grants.
- drop_count saturates at 2^CNT_WIDTH-1 and never wraps.
- NUM_REQ=1: rr_ptr stays 0.

Optional Feature:
- Macro: FIFO_WR_ARB_RETRY_EN
- Defined: on failure in WAIT, hold fifo_data_in and grant_id and return to IDLE-retry.
  - The same word is reissued (ISSUE) as soon as fifo_full=0, ahead of all new requests.
  - No new req_grant is issued while the retry is pending; rr_ptr is unchanged until the write succeeds.
  - drop_count is not incremented.
- Undefined: on failure, drop_count += 1 (saturating), rr_ptr advances as on success, and the FSM goes to IDLE. The word is lost.

Test Plan:
- Reset, then req_valid=4'b1111, FIFO never full -> grants in order 0,1,2,3,0; each req_grant pulse is 3 cycles apart; fifo_wr_en high 1 cycle per grant; drop_count=0.
- req_valid=4'b0100 only, req_data[2]=16'hBEEF -> grant_id=2; fifo_data_in=16'hBEEF with fifo_wr_en=1 in the cycle after the grant edge; wr_ack next cycle.
- FIFO (depth 8) pre-filled to 8 entries, req_valid=4'b0001 -> no req_grant while fifo_full=1; after one FIFO read, grant occurs within 1 cycle of fifo_full falling.
- Force fifo_overflow=1 in WAIT, macro undefined -> drop_count 0->1; next grant goes to grant_id+1. Macro defined -> same word reissued, drop_count stays 0, no new req_grant until wr_ack.
- Assert rst during ISSUE -> fifo_wr_en=0, busy=0, req_grant=0 immediately (asynchronously); after release, first grant goes to requester 0.
- Force 300 consecutive failures, macro undefined -> drop_count saturates at 255.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake and FIFO write-side signals of fifo_wr_arbiter.
// master = arbiter side, slave = requesters plus FIFO.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_grant;
  logic [IDW-1:0]                grant_id;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_full;
  logic                          fifo_wr_ack;
  logic                          fifo_overflow;
  logic                          busy;
  logic [CNT_WIDTH-1:0]          drop_count;

  modport master (
    input  req_valid, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
    output req_grant, grant_id, fifo_wr_en, fifo_data_in, busy, drop_count
  );

  modport slave (
    output req_valid, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
    input  req_grant, grant_id, fifo_wr_en, fifo_data_in, busy, drop_count
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Macro FIFO_WR_ARB_RETRY_EN: a failed write is reissued instead of being dropped and counted.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                r_state,    w_state_nx;
  logic [IDW-1:0]        r_rr_ptr,   w_rr_nx;
  logic [IDW-1:0]        r_grant_id, w_grant_id_nx;
  logic [NUM_REQ-1:0]    r_grant,    w_grant_nx;
  logic                  r_wr_en,    w_wr_en_nx;
  logic [DATA_WIDTH-1:0] r_data,     w_data_nx;
  logic [CNT_WIDTH-1:0]  r_drop,     w_drop_nx;
`ifdef FIFO_WR_ARB_RETRY_EN
  logic                  r_retry,    w_retry_nx;
`endif

  logic [DATA_WIDTH-1:0] w_words [NUM_REQ];
  logic [IDW:0]          w_sum;
  logic [IDW-1:0]        w_sel;
  logic [IDW-1:0]        w_next_id;
  logic                  w_any;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_words[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NUM_REQ)) w_sum = w_sum - (IDW+1)'(NUM_REQ);
      if (bus.req_valid[w_sum[IDW-1:0]]) begin
        w_any = 1'b1;
        w_sel = w_sum[IDW-1:0];
      end
    end
  end

  assign w_next_id = (r_grant_id == IDW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

  always_comb begin
    w_state_nx    = r_state;
    w_rr_nx       = r_rr_ptr;
    w_grant_id_nx = r_grant_id;
    w_grant_nx    = '0;
    w_wr_en_nx    = 1'b0;
    w_data_nx     = r_data;
    w_drop_nx     = r_drop;
`ifdef FIFO_WR_ARB_RETRY_EN
    w_retry_nx    = r_retry;
`endif
    case (r_state)
      IDLE: begin
`ifdef FIFO_WR_ARB_RETRY_EN
        if (r_retry) begin
          // A pending retry owns the port; new requests wait until it succeeds.
          if (!bus.fifo_full) begin
            w_wr_en_nx = 1'b1;
            w_state_nx = ISSUE;
          end
        end else
`endif
        if (w_any && !bus.fifo_full) begin
          w_grant_nx[w_sel] = 1'b1;
          w_grant_id_nx     = w_sel;
          w_data_nx         = w_words[w_sel];
          w_wr_en_nx        = 1'b1;
          w_state_nx        = ISSUE;
        end
      end
      ISSUE: w_state_nx = WAIT;
      WAIT: begin
        w_state_nx = IDLE;
        if (bus.fifo_wr_ack) begin
          w_rr_nx = w_next_id;
`ifdef FIFO_WR_ARB_RETRY_EN
          w_retry_nx = 1'b0;
`endif
        end else begin
`ifdef FIFO_WR_ARB_RETRY_EN
          w_retry_nx = 1'b1;
`else
          w_rr_nx = w_next_id;
          if (r_drop != '1) w_drop_nx = r_drop + 1'b1;
`endif
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_grant    <= '0;
      r_wr_en    <= 1'b0;
      r_data     <= '0;
      r_drop     <= '0;
`ifdef FIFO_WR_ARB_RETRY_EN
      r_retry    <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_rr_ptr   <= w_rr_nx;
      r_grant_id <= w_grant_id_nx;
      r_grant    <= w_grant_nx;
      r_wr_en    <= w_wr_en_nx;
      r_data     <= w_data_nx;
      r_drop     <= w_drop_nx;
`ifdef FIFO_WR_ARB_RETRY_EN
      r_retry    <= w_retry_nx;
`endif
    end
  end

  assign bus.req_grant    = r_grant;
  assign bus.grant_id     = r_grant_id;
  assign bus.fifo_wr_en   = r_wr_en;
  assign bus.fifo_data_in = r_data;
  assign bus.busy         = (r_state != IDLE);
  assign bus.drop_count   = r_drop;

  // Both flags together is a FIFO fault; the logic above treats it as success.
  a_ack_ovf_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(r_state == WAIT && bus.fifo_wr_ack && bus.fifo_overflow))
    else $error("fifo_wr_arbiter: wr_ack and overflow asserted together");
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: depth-8 FIFO model, write scoreboard, vector table
// for round-robin selection, and directed sequences for full/failure/reset corners.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 16;
  localparam int CNT_WIDTH  = 8;
  localparam int DEPTH      = 8;
  localparam int LIMIT      = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] id; logic [15:0] data; } wr_t;
  typedef struct { logic [3:0] valid; logic [1:0] exp_id; } vec_t;

  wr_t  sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  logic [15:0] words [NUM_REQ];
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] = words[i];
  end

  // FIFO write-side model; force flags turn accepted writes into failures.
  int   m_cnt;
  logic m_rd, m_fill, m_force_ovf, m_force_none;
  logic m_acc, m_rej;
  assign m_acc = bus.fifo_wr_en && !m_force_none && !m_force_ovf && (m_cnt != DEPTH);
  assign m_rej = bus.fifo_wr_en && !m_force_none && !m_acc;
  assign bus.fifo_full = (m_cnt == DEPTH);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt             <= 0;
      bus.fifo_wr_ack   <= 1'b0;
      bus.fifo_overflow <= 1'b0;
    end else begin
      bus.fifo_wr_ack   <= m_acc;
      bus.fifo_overflow <= m_rej;
      if (m_fill) m_cnt <= DEPTH;
      else        m_cnt <= m_cnt + (m_acc ? 1 : 0) - ((m_rd && m_cnt > 0) ? 1 : 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Every write pulse is matched against the next expected {id, data}.
  logic mon_prev_we = 1'b0;
  always @(negedge clk) begin
    if (!rst && bus.fifo_wr_en) begin
      chk("wr_en_single_cycle", 32'(mon_prev_we), 32'd0);
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected_write: got id %0d data 0x%0h, want no write",
                 bus.grant_id, bus.fifo_data_in);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        chk("sb_wr_id", 32'(bus.grant_id), 32'(e.id));
        chk("sb_wr_data", 32'(bus.fifo_data_in), 32'(e.data));
      end
    end
    mon_prev_we <= bus.fifo_wr_en;
  end

  task automatic wait_grant(input string name, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.req_grant == '0 && cyc < LIMIT);
    chk({name, "_granted"}, 32'(bus.req_grant != '0), 32'd1);
  endtask

  initial begin
    int   cyc;
    int   n_gr;
    vec_t vecs[10];
    logic [3:0] oh;

    vecs[0] = '{4'b0100, 2'd2};
    vecs[1] = '{4'b0011, 2'd0};
    vecs[2] = '{4'b0011, 2'd1};
    vecs[3] = '{4'b1001, 2'd3};
    vecs[4] = '{4'b1010, 2'd1};
    vecs[5] = '{4'b0001, 2'd0};
    vecs[6] = '{4'b1111, 2'd1};
    vecs[7] = '{4'b0101, 2'd2};
    vecs[8] = '{4'b1000, 2'd3};
    vecs[9] = '{4'b0110, 2'd1};

    rst = 1'b1;
    bus.req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) words[i] = 16'h0;
    m_rd = 1'b1; m_fill = 1'b0; m_force_ovf = 1'b0; m_force_none = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(bus.req_grant), 32'd0);
    chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
    chk("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    chk("rst_data", 32'(bus.fifo_data_in), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_drop", 32'(bus.drop_count), 32'd0);

    // All four requesting continuously: 0,1,2,3,0 every third cycle.
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) words[i] = 16'h1000 + 16'(i);
    for (int g = 0; g < 5; g++) sb_q.push_back(wr_t'{2'(g % 4), 16'h1000 + 16'(g % 4)});
    bus.req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant("rr_all", cyc);
      chk($sformatf("rr_spacing_%0d", g), 32'(cyc), (g == 0) ? 32'd1 : 32'd3);
      oh = 4'b0001 << (g % 4);
      chk($sformatf("rr_grant_%0d", g), 32'(bus.req_grant), 32'(oh));
      chk($sformatf("rr_id_%0d", g), 32'(bus.grant_id), 32'(g % 4));
    end
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    chk("rr_drop", 32'(bus.drop_count), 32'd0);
    chk("rr_idle_busy", 32'(bus.busy), 32'd0);

    // Vector table; pointer sits at 1 entering it.
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < NUM_REQ; i++) words[i] = 16'hA000 + 16'(v * 16 + i);
      if (v == 0) words[2] = 16'hBEEF;
      sb_q.push_back(wr_t'{vecs[v].exp_id, words[vecs[v].exp_id]});
      bus.req_valid = vecs[v].valid;
      wait_grant($sformatf("vec%0d", v), cyc);
      oh = 4'b0001 << vecs[v].exp_id;
      chk($sformatf("vec%0d_id", v), 32'(bus.grant_id), 32'(vecs[v].exp_id));
      chk($sformatf("vec%0d_grant", v), 32'(bus.req_grant), 32'(oh));
      chk($sformatf("vec%0d_busy", v), 32'(bus.busy), 32'd1);
      if (v == 0) begin
        chk("beef_data", 32'(bus.fifo_data_in), 32'h0000BEEF);
        chk("beef_wr_en", 32'(bus.fifo_wr_en), 32'd1);
      end
      bus.req_valid = '0;
      repeat (2) @(negedge clk);
    end

    // FIFO full: no grant until one entry is read out.
    m_rd = 1'b0; m_fill = 1'b1;
    @(negedge clk);
    m_fill = 1'b0;
    chk("prefill_full", 32'(bus.fifo_full), 32'd1);
    words[0] = 16'hC0DE;
    sb_q.push_back(wr_t'{2'd0, 16'hC0DE});
    bus.req_valid = 4'b0001;
    n_gr = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.req_grant != '0) n_gr++;
    end
    chk("full_no_grant", 32'(n_gr), 32'd0);
    chk("full_not_busy", 32'(bus.busy), 32'd0);
    m_rd = 1'b1;
    wait_grant("after_read", cyc);
    chk("grant_after_full_fall", 32'(cyc), 32'd2);
    chk("after_read_id", 32'(bus.grant_id), 32'd0);
    bus.req_valid = '0;
    repeat (2) @(negedge clk);

    // One overflow on requester 2; pointer is 1 entering this.
    for (int i = 0; i < NUM_REQ; i++) words[i] = 16'h4000 + 16'(i);
    m_force_ovf = 1'b1;
    sb_q.push_back(wr_t'{2'd2, 16'h4002});
`ifdef FIFO_WR_ARB_RETRY_EN
    sb_q.push_back(wr_t'{2'd2, 16'h4002});
`endif
    bus.req_valid = 4'b0100;
    wait_grant("ovf", cyc);
    chk("ovf_id", 32'(bus.grant_id), 32'd2);
    for (int i = 0; i < NUM_REQ; i++) words[i] = 16'h5000 + 16'(i);
    sb_q.push_back(wr_t'{2'd3, 16'h5003});
    bus.req_valid = 4'b1111;
    @(negedge clk);
    m_force_ovf = 1'b0;
    wait_grant("after_ovf", cyc);
`ifdef FIFO_WR_ARB_RETRY_EN
    chk("retry_grant_gap", 32'(cyc), 32'd5);
    chk("retry_drop", 32'(bus.drop_count), 32'd0);
`else
    chk("drop_grant_gap", 32'(cyc), 32'd2);
    chk("drop_count_one", 32'(bus.drop_count), 32'd1);
`endif
    chk("after_ovf_id", 32'(bus.grant_id), 32'd3);
    bus.req_valid = '0;
    repeat (2) @(negedge clk);

    // Reset while the write is in ISSUE.
    words[1] = 16'h6001;
    sb_q.push_back(wr_t'{2'd1, 16'h6001});
    bus.req_valid = 4'b0010;
    wait_grant("pre_rst", cyc);
    chk("pre_rst_id", 32'(bus.grant_id), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_grant", 32'(bus.req_grant), 32'd0);
    chk("async_rst_id", 32'(bus.grant_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) words[i] = 16'h7000 + 16'(i);
    sb_q.push_back(wr_t'{2'd0, 16'h7000});
    bus.req_valid = 4'b1111;
    wait_grant("post_rst", cyc);
    chk("post_rst_latency", 32'(cyc), 32'd1);
    chk("post_rst_id", 32'(bus.grant_id), 32'd0);
    bus.req_valid = '0;
    repeat (2) @(negedge clk);

`ifndef FIFO_WR_ARB_RETRY_EN
    // 300 unanswered writes: the drop counter must stop at 255.
    m_force_none = 1'b1;
    words[0] = 16'h8000;
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 300; i++) begin
      sb_q.push_back(wr_t'{2'd0, 16'h8000});
      wait_grant("sat", cyc);
      if (i == 100) chk("drop_at_100", 32'(bus.drop_count), 32'd100);
      if (i == 256) chk("drop_sat_256", 32'(bus.drop_count), 32'd255);
    end
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    chk("drop_sat_final", 32'(bus.drop_count), 32'd255);
    m_force_none = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
